// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller and its MDU timer.
package pipe_pkg;

    localparam int REG_W     = 5;
    localparam int MDU_CNT_W = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Counter preload for a given latency; clamped so an out-of-range
    // parameter still yields at least two busy cycles and no wrap.
    function automatic logic [MDU_CNT_W-1:0] mdu_load_value(input int lat);
        int clamped;
        clamped = lat;
        if (clamped < 2)
            clamped = 2;
        if (clamped > 255)
            clamped = 255;
        return MDU_CNT_W'(clamped - 1);
    endfunction

endpackage

// File: rtl/pipe_mdu_timer.sv
// Tracks an in-flight multiply/divide: IDLE/MDU_BUSY FSM plus a down-counter
// that reports busy and a one-cycle done pulse on the final busy cycle.
module pipe_mdu_timer
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam logic [MDU_CNT_W-1:0] MDU_LOAD = mdu_load_value(MDU_LAT);

    mdu_state_e             state_q;
    mdu_state_e             state_d;
    logic [MDU_CNT_W-1:0]   cnt_q;
    logic [MDU_CNT_W-1:0]   cnt_d;
    logic                   done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter holds at zero on the last busy cycle, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = MDU_LOAD;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdu_busy = (state_q == MDU_BUSY);
    assign mdu_done = done_d;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU stalls, branch/imem flushes.
// Optional HAZ_PERF_CNT_EN adds stall_cycles/flush_cycles counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mdu_op,
    input  logic             id_hilo_rd,
    input  logic             id_pcsrc,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             imem_rdy,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             mdu_busy,
    output logic             mdu_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    logic load_use;
    logic mdu_hz;
    logic mdu_start;

    // Register $0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = ex_memread && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        mdu_hz    = mdu_busy && (id_mdu_op || id_hilo_rd);
        stall_id  = load_use || mdu_hz;
        stall_pc  = stall_id || !imem_rdy;
        bubble_ex = stall_id;
        flush_id  = !stall_id && (id_pcsrc || !imem_rdy);
    end

    // A stalled MDU op is not launched; it retries once the stall clears.
    assign mdu_start = id_mdu_op && !stall_id;

    pipe_mdu_timer #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mdu_start),
        .mdu_busy (mdu_busy),
        .mdu_done (mdu_done)
    );

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_pc)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_id)
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MDU_LAT=4): directed hazard
// scenarios followed by random traffic, compared against a cycle model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_mdu_op, id_hilo_rd, id_pcsrc, ex_memread, imem_rdy;
    logic       stall_pc, stall_id, flush_id, bubble_ex, mdu_busy, mdu_done;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: cycles of MDU activity still ahead (0 = idle).
    int          mdu_left;
    logic [31:0] m_stall_cnt, m_flush_cnt;
    logic        e_stall_id, e_stall_pc, e_flush_id, e_busy, e_done;

    pipe_hazard_ctrl #(.MDU_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_mdu_op  (id_mdu_op),
        .id_hilo_rd (id_hilo_rd),
        .id_pcsrc   (id_pcsrc),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .imem_rdy   (imem_rdy),
        .stall_pc   (stall_pc),
        .stall_id   (stall_id),
        .flush_id   (flush_id),
        .bubble_ex  (bubble_ex),
        .mdu_busy   (mdu_busy),
        .mdu_done   (mdu_done)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic mdu_op,
                                 input logic hilo, input logic pcsrc,
                                 input logic memread, input logic [4:0] exrt,
                                 input logic rdy);
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = uses_rt;
        id_mdu_op  = mdu_op;
        id_hilo_rd = hilo;
        id_pcsrc   = pcsrc;
        ex_memread = memread;
        ex_rt      = exrt;
        imem_rdy   = rdy;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic lu;
        if (!rst_n) begin
            mdu_left    = 0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end
        lu = ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        e_busy     = (mdu_left > 0);
        e_done     = (mdu_left == 1);
        e_stall_id = lu || (e_busy && (id_mdu_op || id_hilo_rd));
        e_stall_pc = e_stall_id || !imem_rdy;
        e_flush_id = !e_stall_id && (id_pcsrc || !imem_rdy);
        check1({tag, ".stall_id"},  stall_id,  e_stall_id);
        check1({tag, ".stall_pc"},  stall_pc,  e_stall_pc);
        check1({tag, ".flush_id"},  flush_id,  e_flush_id);
        check1({tag, ".bubble_ex"}, bubble_ex, e_stall_id);
        check1({tag, ".mdu_busy"},  mdu_busy,  e_busy);
        check1({tag, ".mdu_done"},  mdu_done,  e_done);
`ifdef HAZ_PERF_CNT_EN
        check32({tag, ".stall_cycles"}, stall_cycles, m_stall_cnt);
        check32({tag, ".flush_cycles"}, flush_cycles, m_flush_cnt);
`endif
    endtask

    // Check the settled outputs, advance the model across the clock edge.
    task automatic stepCycle(input string tag);
        #1;
        checkOutput(tag);
        if (rst_n) begin
            if (mdu_left > 0)
                mdu_left = mdu_left - 1;
            else if (id_mdu_op && !e_stall_id)
                mdu_left = LAT;
            if (e_stall_pc) m_stall_cnt = m_stall_cnt + 32'd1;
            if (e_flush_id) m_flush_cnt = m_flush_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        mdu_left    = 0;
        m_stall_cnt = '0;
        m_flush_cnt = '0;
        rst_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        stepCycle("reset0");
        stepCycle("reset1");
        rst_n = 1'b1;
        stepCycle("idle");

        // Load-use on rs: one stall cycle, then the bubble clears memread.
        applyStimulus(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1);
        stepCycle("lu_rs");
        applyStimulus(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        stepCycle("lu_cleared");
        // Load to $0 never stalls; rt match only counts when rt is read.
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
        stepCycle("lu_r0");
        applyStimulus(5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        stepCycle("lu_rt_unused");
        applyStimulus(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
        stepCycle("lu_rt_used");

        // Taken branch flushes; a load-use stall overrides the flush.
        applyStimulus(5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
        stepCycle("branch");
        applyStimulus(5'd4, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1);
        stepCycle("branch_lu");
        applyStimulus(5'd4, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1);
        stepCycle("branch_retry");

        // MDU op, then mfhi each cycle: stalled through mdu_done.
        applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        stepCycle("mdu_issue");
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 1; i <= 5; i++)
            stepCycle($sformatf("mfhi_c%0d", i));

        // Back-to-back MDU ops: the second waits for IDLE.
        applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 7; i++)
            stepCycle($sformatf("mdu_b2b_c%0d", i));
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            stepCycle($sformatf("mdu_drain_c%0d", i));

        // Instruction memory not ready for three cycles.
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            stepCycle($sformatf("imem_wait%0d", i));
        // Load-use together with imem not ready: stall wins over flush.
        applyStimulus(5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
        stepCycle("lu_imem");
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        stepCycle("imem_ok");

        // Reset in the middle of an MDU operation.
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        stepCycle("mdu_rst_issue");
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        stepCycle("mdu_rst_b1");
        stepCycle("mdu_rst_b2");
        rst_n = 1'b0;
        stepCycle("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            stepCycle($sformatf("post_reset%0d", i));

        // Random traffic with small register numbers to provoke matches.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 4) != 0));
            stepCycle("rand");
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 32, multiply/divide unit latency in cycles (legal 2..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 id_rs, id_rt  input  5 each  source register fields of the instruction in IF/ID.
REQ-005 id_uses_rt  input  1  ID instruction reads rt.
REQ-006 id_mdu_op  input  1  ID instruction is mult/multu/div/divu.
REQ-007 id_hilo_rd  input  1  ID instruction is mfhi/mflo.
REQ-008 id_pcsrc  input  1  ID resolved a taken branch/jump.
REQ-009 ex_memread, ex_rt  input  1, 5  ID/EX holds a load and its destination register.
REQ-010 imem_rdy  input  1  instruction memory data valid this cycle.
REQ-011 stall_pc  output  1  hold PC.
REQ-012 stall_id  output  1  hold IF/ID register (drives its Stall_ID).
REQ-013 flush_id  output  1  load bubble into IF/ID (drives its ID_PCSrc).
REQ-014 bubble_ex  output  1  load NOP into ID/EX.
REQ-015 mdu_busy  output  1  MDU operation in flight.
REQ-016 mdu_done  output  1  one-cycle pulse when MDU result is available.

Function
REQ-017 load_use SHALL equal ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-018 mdu_hz SHALL equal (state==MDU_BUSY) & (id_mdu_op | id_hilo_rd).
REQ-019 Combinational outputs: stall_id = load_use | mdu_hz; stall_pc = stall_id | ~imem_rdy; bubble_ex = stall_id.
REQ-020 flush_id = ~stall_id & (id_pcsrc | ~imem_rdy); stall has priority, held branch re-asserts next cycle.
REQ-021 FSM states IDLE, MDU_BUSY; encoding 1 bit.
REQ-022 IDLE -> MDU_BUSY when id_mdu_op & ~stall_id; counter loads MDU_LAT-1.
REQ-023 MDU_BUSY: counter decrements each cycle; at counter==0 next state IDLE, mdu_done=1 that cycle.
REQ-024 mdu_busy = (state==MDU_BUSY); an MDU op issued in MDU_BUSY stalls until IDLE, then issues in the first IDLE cycle.
REQ-025 Counter width 8 bits; no wrap below zero.
REQ-026 Load-use stall lasts exactly 1 cycle (bubble clears ex_memread); latency of all stall/flush outputs is 0 cycles.
REQ-027 Simultaneous load_use and ~imem_rdy: stall_id=1, flush_id=0, stall_pc=1.

Reset
REQ-028 rst_n low SHALL force state=IDLE, counter=0, mdu_done=0, perf counters=0 immediately, including mid-MDU operation.
REQ-029 During reset combinational outputs follow REQ-019/020 with state=IDLE.

Configuration
REQ-030 Macro HAZ_PERF_CNT_EN defined: add outputs stall_cycles[31:0] (increments per cycle stall_pc=1) and flush_cycles[31:0] (increments per cycle flush_id=1), both wrapping 0xFFFFFFFF->0.
REQ-031 Macro undefined: these ports and registers SHALL not exist; remaining behaviour identical.

Structure
REQ-032 Shared package pipe_pkg holds state enum constants (IDLE=0, MDU_BUSY=1), REG_W=5, MDU_CNT_W=8.
REQ-033 One sub-module pipe_mdu_timer (counter + FSM, outputs mdu_busy/mdu_done); hazard equations remain in the top.

Verification
REQ-034 ex_memread=1, ex_rt=8, id_rs=8 -> stall_id=stall_pc=bubble_ex=1 one cycle, flush_id=0.
REQ-035 ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
REQ-036 id_pcsrc=1, no hazard -> flush_id=1, stall_id=0; with load_use also 1 -> flush_id=0 until stall clears.
REQ-037 MDU_LAT=4: id_mdu_op at cycle 0, id_hilo_rd from cycle 1 -> stall_id=1 cycles 1-4, mdu_done at cycle 4, stall released cycle 5.
REQ-038 imem_rdy=0 three cycles -> stall_pc=1, flush_id=1 each cycle; stall_cycles=3 with HAZ_PERF_CNT_EN.
REQ-039 rst_n asserted at cycle 2 of MDU_BUSY -> mdu_busy=0 immediately, no mdu_done after release.
